gpioemu_gcdx: RTL and testbench

Parametrised second-generation GCD peripheral on the gpioemu SoC bus. Adds configurable operand width and base address, a selectable Euclid-subtraction or Stein-binary datapath, a result FIFO, abort, and sticky error flags. Sits behind the same srd/swr/saddress bus as gpioemu; the Linux driver polls STATUS and pops RESULT.

---
 rtl/gpioemu_gcdx_pkg.sv | 32 +++
 rtl/gcdx_fifo.sv | 67 ++++++
 rtl/gpioemu_gcdx.sv | 226 ++++++++++++++++++++++
 tb/tb_gpioemu_gcdx.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpioemu_gcdx_pkg.sv
// Shared definitions for the gpioemu GCD peripheral: register map, STATUS/CTRL fields,
// datapath FSM encoding.
package gpioemu_gcdx_pkg;

   localparam logic [15:0] OffA1     = 16'h0000;
   localparam logic [15:0] OffA2     = 16'h0004;
   localparam logic [15:0] OffResult = 16'h0008;
   localparam logic [15:0] OffStatus = 16'h000C;
   localparam logic [15:0] OffCtrl   = 16'h0010;

   localparam int unsigned StatBusyBit   = 0;
   localparam int unsigned StatEmptyBit  = 1;
   localparam int unsigned StatFullBit   = 2;
   localparam int unsigned StatCntLsb    = 4;
   localparam int unsigned StatRejectBit = 8;
   localparam int unsigned StatUnderBit  = 9;
   localparam int unsigned StatZeroBit   = 10;

   localparam int unsigned CtrlModeBit  = 0;
   localparam int unsigned CtrlFlushBit = 1;
   localparam int unsigned CtrlAbortBit = 2;

   typedef enum logic [2:0] {
      StIdle,
      StEuclid,
      StShift,
      StOdd,
      StLoop,
      StDone
   } state_e;

endpackage

// File: rtl/gcdx_fifo.sv
// Result FIFO for the GCD peripheral: power-of-two depth, occupancy count, flush
// that overrides a simultaneous push or pop.
module gcdx_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [Width-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [Width-1:0]         rdata_o,
   output logic [$clog2(Depth):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);
   localparam int unsigned PtrW = $clog2(Depth);
   localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, rptr_q;
   logic [PtrW:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == FullCnt);
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i & ~flush_i & ~full_o;
   assign do_pop  = pop_i & ~flush_i & ~empty_o;
   assign rdata_o = mem_q[rptr_q];
   assign count_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (flush_i) begin
         cnt_d = '0;
      end else begin
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
         end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/gpioemu_gcdx.sv
// GCD peripheral on the gpioemu srd/swr bus: Euclid-subtraction or Stein datapath,
// result FIFO, abort/flush, sticky error flags and a completed-job counter on gpio_out.
module gpioemu_gcdx
   import gpioemu_gcdx_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter logic [15:0] BASE_ADDR = 16'h00D8,
   parameter int unsigned RES_DEPTH = 4
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic [15:0] saddress,
   input  logic        srd,
   input  logic        swr,
   input  logic [31:0] sdata_in,
   output logic [31:0] sdata_out,
   input  logic [31:0] gpio_in,
   input  logic        gpio_latch,
   output logic [31:0] gpio_out,
   output logic [31:0] gpio_in_s_insp
);
   localparam int unsigned CntW = $clog2(RES_DEPTH) + 1;
   localparam int unsigned KW   = $clog2(DATA_W + 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] a1_q, a2_q, a_q, a_d, b_q, b_d, push_data, fifo_rdata, wdata;
   logic [KW-1:0]     k_q, k_d;
   logic [15:0]       cnt_q, off;
   logic [31:0]       sdata_q, insp_q, status, rd_data;
   logic [CntW-1:0]   fifo_cnt;
   logic srd_q, swr_q, wr_ev, rd_ev, mode_q, rej_q, rej_d, und_q, und_d, zf_q;
   logic sel_a1, sel_a2, sel_res, sel_stat, sel_ctrl, flush, abort, launch, reject;
   logic busy, zero_op, push, zero_job, done, pop_req, fifo_full, fifo_empty;

   // A simultaneous read edge is dropped in favour of the write.
   assign wr_ev    = swr & ~swr_q;
   assign rd_ev    = srd & ~srd_q & ~wr_ev;
   assign off      = saddress - BASE_ADDR;
   assign sel_a1   = (off == OffA1);
   assign sel_a2   = (off == OffA2);
   assign sel_res  = (off == OffResult);
   assign sel_stat = (off == OffStatus);
   assign sel_ctrl = (off == OffCtrl);
   assign wdata    = sdata_in[DATA_W-1:0];

   assign busy    = (state_q != StIdle);
   assign flush   = wr_ev & sel_ctrl & sdata_in[CtrlFlushBit];
   assign abort   = wr_ev & sel_ctrl & sdata_in[CtrlAbortBit];
   assign launch  = wr_ev & sel_a2 & ~busy & ~fifo_full;
   assign reject  = wr_ev & sel_a2 & (busy | fifo_full);
   assign zero_op = (a_q == '0) || (b_q == '0);
   assign done    = push & ~abort;
   assign pop_req = rd_ev & sel_res;

   gcdx_fifo #(
      .Depth (RES_DEPTH),
      .Width (DATA_W)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (n_reset),
      .flush_i (flush),
      .push_i  (done),
      .wdata_i (push_data),
      .pop_i   (pop_req),
      .rdata_o (fifo_rdata),
      .count_o (fifo_cnt),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         k_q     <= k_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle:   if (launch) state_d = mode_q ? StShift : StEuclid;
            StEuclid: if (zero_op || a_q == b_q) state_d = StIdle;
            StShift: begin
               if (zero_op)                state_d = StIdle;
               else if (a_q[0] || b_q[0])  state_d = StOdd;
            end
            StOdd:    if (a_q[0]) state_d = StLoop;
            StLoop:   if (b_q == '0) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      a_d       = a_q;
      b_d       = b_q;
      k_d       = k_q;
      push      = 1'b0;
      push_data = '0;
      zero_job  = 1'b0;
      case (state_q)
         StIdle: begin
            if (launch) begin
               a_d = a1_q;
               b_d = wdata;
               k_d = '0;
            end
         end
         StEuclid: begin
            if (zero_op) begin
               push      = 1'b1;
               push_data = a_q | b_q;
               zero_job  = 1'b1;
            end else if (a_q == b_q) begin
               push      = 1'b1;
               push_data = a_q;
            end else if (a_q > b_q) begin
               a_d = a_q - b_q;
            end else begin
               b_d = b_q - a_q;
            end
         end
         StShift: begin
            if (zero_op) begin
               push      = 1'b1;
               push_data = a_q | b_q;
               zero_job  = 1'b1;
            end else if (!a_q[0] && !b_q[0]) begin
               a_d = a_q >> 1;
               b_d = b_q >> 1;
               k_d = k_q + 1'b1;
            end
         end
         StOdd: if (!a_q[0]) a_d = a_q >> 1;
         StLoop: begin
            // Keep a odd and a <= b; subtracting two odds makes b even again.
            if (b_q != '0) begin
               if (!b_q[0]) begin
                  b_d = b_q >> 1;
               end else if (a_q > b_q) begin
                  a_d = b_q;
                  b_d = a_q - b_q;
               end else begin
                  b_d = b_q - a_q;
               end
            end
         end
         StDone: begin
            push      = 1'b1;
            push_data = a_q << k_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      status                          = '0;
      status[StatBusyBit]             = busy;
      status[StatEmptyBit]            = fifo_empty;
      status[StatFullBit]             = fifo_full;
      status[StatCntLsb +: 4]         = 4'(fifo_cnt);
      status[StatRejectBit]           = rej_q;
      status[StatUnderBit]            = und_q;
      status[StatZeroBit]             = zf_q;
      rd_data = '0;
      if (sel_a1)        rd_data = 32'(a1_q);
      else if (sel_a2)   rd_data = 32'(a2_q);
      else if (sel_res)  rd_data = fifo_empty ? '0 : 32'(fifo_rdata);
      else if (sel_stat) rd_data = status;
      else if (sel_ctrl) rd_data = {31'b0, mode_q};
      rej_d = rej_q;
      und_d = und_q;
      if (rd_ev && sel_stat)  begin
         rej_d = 1'b0;
         und_d = 1'b0;
      end
      if (reject)                 rej_d = 1'b1;
      if (pop_req && fifo_empty)  und_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         srd_q   <= 1'b0;
         swr_q   <= 1'b0;
         a1_q    <= '0;
         a2_q    <= '0;
         mode_q  <= 1'b0;
         sdata_q <= '0;
         insp_q  <= '0;
         cnt_q   <= '0;
         rej_q   <= 1'b0;
         und_q   <= 1'b0;
         zf_q    <= 1'b0;
      end else begin
         srd_q <= srd;
         swr_q <= swr;
         if (wr_ev && sel_a1)   a1_q   <= wdata;
         if (wr_ev && sel_a2)   a2_q   <= wdata;
         if (wr_ev && sel_ctrl) mode_q <= sdata_in[CtrlModeBit];
         if (rd_ev)             sdata_q <= rd_data;
         if (gpio_latch)        insp_q <= gpio_in;
         if (done) begin
            cnt_q <= cnt_q + 16'd1;
            zf_q  <= zero_job;
         end
         rej_q <= rej_d;
         und_q <= und_d;
      end
   end

   assign sdata_out      = sdata_q;
   assign gpio_in_s_insp = insp_q;
   assign gpio_out       = {busy, 15'b0, cnt_q};

endmodule

// File: tb/tb_gpioemu_gcdx.sv
// Randomised and directed bench for gpioemu_gcdx against a plain-arithmetic GCD model
// with a queue standing in for the result FIFO.
module tb_gpioemu_gcdx;
   localparam logic [15:0] Base    = 16'h00D8;
   localparam logic [15:0] RegA1   = Base + 16'h00;
   localparam logic [15:0] RegA2   = Base + 16'h04;
   localparam logic [15:0] RegRes  = Base + 16'h08;
   localparam logic [15:0] RegStat = Base + 16'h0C;
   localparam logic [15:0] RegCtrl = Base + 16'h10;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic [15:0] saddress = '0;
   logic        srd = 1'b0, swr = 1'b0, gpio_latch = 1'b0;
   logic [31:0] sdata_in = '0, gpio_in = '0;
   logic [31:0] sdata_out, gpio_out, gpio_in_s_insp;
   logic [31:0] sdata_out16, gpio_out16, insp16;

   int errors = 0, checks = 0, cyc = 0, jobs = 0;
   bit last_zero = 0;
   logic [31:0] exp_q[$];

   gpioemu_gcdx dut (
      .clk(clk), .n_reset(n_reset), .saddress(saddress), .srd(srd), .swr(swr),
      .sdata_in(sdata_in), .sdata_out(sdata_out), .gpio_in(gpio_in),
      .gpio_latch(gpio_latch), .gpio_out(gpio_out), .gpio_in_s_insp(gpio_in_s_insp)
   );

   gpioemu_gcdx #(.DATA_W(16)) dut16 (
      .clk(clk), .n_reset(n_reset), .saddress(saddress), .srd(srd), .swr(swr),
      .sdata_in(sdata_in), .sdata_out(sdata_out16), .gpio_in(gpio_in),
      .gpio_latch(gpio_latch), .gpio_out(gpio_out16), .gpio_in_s_insp(insp16)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Subtraction-Euclid latency = sum of division quotients (steps + 1 edge for a==b).
   function automatic int euclid_lat(input logic [31:0] a, input logic [31:0] b);
      int s = 0;
      logic [31:0] t;
      if (a == 0 || b == 0) return 1;
      while (b != 0) begin
         s += int'(a / b);
         t = a % b;
         a = b;
         b = t;
      end
      return s;
   endfunction

   function automatic logic [31:0] exp_status(input bit busy, input bit rej, input bit und);
      logic [31:0] s = '0;
      s[0]   = busy;
      s[1]   = (exp_q.size() == 0);
      s[2]   = (exp_q.size() == 4);
      s[7:4] = 4'(exp_q.size());
      s[8]   = rej;
      s[9]   = und;
      s[10]  = last_zero;
      return s;
   endfunction

   task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
      saddress = addr;
      sdata_in = data;
      swr = 1'b1;
      @(posedge clk); #1;
      swr = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic bus_read(input logic [15:0] addr, output logic [31:0] data);
      saddress = addr;
      srd = 1'b1;
      @(posedge clk); #1;
      data = sdata_out;
      srd = 1'b0;
      @(posedge clk); #1;
   endtask

   // Returns just after the launch edge with l0 holding that edge's cycle number.
   task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit stein,
                         output int l0);
      bus_write(RegCtrl, {31'b0, stein});
      bus_write(RegA1, a);
      saddress = RegA2;
      sdata_in = b;
      swr = 1'b1;
      @(posedge clk); #1;
      swr = 1'b0;
      l0 = cyc;
   endtask

   task automatic run_job(input string name, input logic [31:0] a, input logic [31:0] b,
                          input bit stein, input int max_lat, input bit exact);
      int l0, lat;
      bit done = 0;
      logic [15:0] c0 = gpio_out[15:0];
      launch(a, b, stein, l0);
      checks++;
      if (gpio_out[31] !== 1'b1) begin
         errors++;
         $display("FAIL %s busy-after-launch: got %b want 1", name, gpio_out[31]);
      end
      for (int i = 0; i < max_lat + 8; i++) begin
         if (gpio_out[15:0] != c0) begin
            done = 1;
            break;
         end
         @(posedge clk); #1;
      end
      lat = cyc - l0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s timeout: no completion within %0d cycles", name, max_lat + 8);
         bus_write(RegCtrl, 32'h4);
         return;
      end else if (exact ? (lat != max_lat) : (lat > max_lat)) begin
         errors++;
         $display("FAIL %s latency: got %0d want %s%0d", name, lat, exact ? "" : "<=", max_lat);
      end
      jobs++;
      last_zero = (a == 0 || b == 0);
      exp_q.push_back(gcd_ref(a, b));
      checks++;
      if (gpio_out !== {1'b0, 15'b0, jobs[15:0]}) begin
         errors++;
         $display("FAIL %s gpio_out: got %h want %h", name, gpio_out, {16'h0, jobs[15:0]});
      end
   endtask

   task automatic pop_check(input string name);
      logic [31:0] r, e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h0;
      bus_read(RegRes, r);
      checks++;
      if (r !== e) begin
         errors++;
         $display("FAIL %s result: got %h want %h", name, r, e);
      end
   endtask

   task automatic status_check(input string name, input logic [31:0] e);
      logic [31:0] r;
      bus_read(RegStat, r);
      checks++;
      if (r !== e) begin
         errors++;
         $display("FAIL %s status: got %h want %h", name, r, e);
      end
   endtask

   task automatic do_reset();
      n_reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 n_reset = 1'b1;
      jobs = 0;
      last_zero = 0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      logic [31:0] r;
      do_reset();
      checks++;
      if (sdata_out !== 0 || gpio_out !== 0 || gpio_in_s_insp !== 0) begin
         errors++;
         $display("FAIL reset outputs: got %h %h %h want 0 0 0", sdata_out, gpio_out,
                  gpio_in_s_insp);
      end
      status_check("reset", 32'h2);
      bus_read(RegCtrl, r);
      checks++;
      if (r !== 0) begin
         errors++;
         $display("FAIL reset ctrl: got %h want 0", r);
      end
   endtask

   task automatic test_unmapped();
      logic [31:0] r;
      bus_write(RegA1, 32'h1234);
      bus_write(16'h00FF, 32'hDEADBEEF);
      bus_read(16'h00DD, r);
      checks++;
      if (r !== 0) begin
         errors++;
         $display("FAIL unmapped read: got %h want 0", r);
      end
      bus_read(RegA1, r);
      checks++;
      if (r !== 32'h1234) begin
         errors++;
         $display("FAIL unmapped a1-kept: got %h want 00001234", r);
      end
      bus_write(RegA1, 32'h12345678);
      bus_read(RegA1, r);
      checks++;
      if (r !== 32'h12345678 || sdata_out16 !== 32'h5678) begin
         errors++;
         $display("FAIL width a1: got %h/%h want 12345678/00005678", r, sdata_out16);
      end
   endtask

   task automatic test_gpio();
      gpio_in = 32'hA5A5A5A5;
      gpio_latch = 1'b1;
      @(posedge clk); #1;
      gpio_latch = 1'b0;
      gpio_in = 32'h0F0F0F0F;
      @(posedge clk); #1;
      checks++;
      if (gpio_in_s_insp !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL gpio latch: got %h want a5a5a5a5", gpio_in_s_insp);
      end
   endtask

   task automatic test_euclid();
      logic [31:0] a, b;
      run_job("euclid100_25", 100, 25, 0, 4, 1);
      pop_check("euclid100_25");
      run_job("euclid56_42", 56, 42, 0, 4, 1);
      pop_check("euclid56_42");
      run_job("euclid_eq", 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 1);
      pop_check("euclid_eq");
      for (int i = 0; i < 6; i++) begin
         a = $urandom_range(1, 3000);
         b = $urandom_range(1, 3000);
         run_job("euclid_rand", a, b, 0, euclid_lat(a, b), 1);
         pop_check("euclid_rand");
      end
   endtask

   task automatic test_stein();
      logic [31:0] a, b, g;
      run_job("stein48_18", 48, 18, 1, 66, 0);
      pop_check("stein48_18");
      run_job("stein_big", 314080416, 7966496, 1, 66, 0);
      pop_check("stein_big");
      for (int i = 0; i < 8; i++) begin
         g = $urandom_range(1, 255) << $urandom_range(0, 3);
         a = $urandom_range(1, 1 << 20) * g;
         b = $urandom_range(1, 1 << 20) * g;
         run_job("stein_rand", a, b, 1, 110, 0);
         pop_check("stein_rand");
      end
   endtask

   task automatic test_zero();
      run_job("stein0_7", 0, 7, 1, 1, 1);
      status_check("zero_flag", exp_status(0, 0, 0));
      pop_check("stein0_7");
      run_job("euclid0_0", 0, 0, 0, 1, 1);
      pop_check("euclid0_0");
   endtask

   task automatic test_fifo_full();
      logic [31:0] r;
      run_job("fill0", 12, 8, 0, 3, 1);
      run_job("fill1", 9, 6, 0, 3, 1);
      run_job("fill2", 7, 7, 0, 1, 1);
      run_job("fill3", 30, 12, 1, 66, 0);
      status_check("full", exp_status(0, 0, 0));
      bus_write(RegA2, 32'h55);
      checks++;
      if (gpio_out !== {16'h0, jobs[15:0]}) begin
         errors++;
         $display("FAIL reject no-launch: got %h want %h", gpio_out, {16'h0, jobs[15:0]});
      end
      status_check("reject_set", exp_status(0, 1, 0));
      status_check("reject_clr", exp_status(0, 0, 0));
      bus_read(RegA2, r);
      checks++;
      if (r !== 32'h55) begin
         errors++;
         $display("FAIL reject a2-stored: got %h want 00000055", r);
      end
      for (int i = 0; i < 5; i++) pop_check("drain");
      status_check("underflow", exp_status(0, 0, 1));
      status_check("underflow_clr", exp_status(0, 0, 0));
   endtask

   task automatic test_flush();
      run_job("fl0", 21, 14, 0, 3, 1);
      run_job("fl1", 64, 48, 1, 66, 0);
      bus_write(RegCtrl, 32'h2);
      exp_q.delete();
      status_check("flush", exp_status(0, 0, 0));
   endtask

   task automatic test_abort();
      int l0;
      logic [31:0] r;
      launch(32'hFFFFFFFF, 32'h1, 0, l0);
      repeat (100) @(posedge clk);
      #1;
      checks++;
      if (gpio_out[31] !== 1'b1) begin
         errors++;
         $display("FAIL abort pre-busy: got %b want 1", gpio_out[31]);
      end
      bus_write(RegCtrl, 32'h4);
      checks++;
      if (gpio_out !== {16'h0, jobs[15:0]}) begin
         errors++;
         $display("FAIL abort gpio_out: got %h want %h", gpio_out, {16'h0, jobs[15:0]});
      end
      status_check("abort", exp_status(0, 0, 0));
      bus_read(RegCtrl, r);
      checks++;
      if (r !== 0) begin
         errors++;
         $display("FAIL abort ctrl-readback: got %h want 0", r);
      end
   endtask

   task automatic test_reset_midjob();
      int l0;
      launch(32'hFFFFFFFF, 32'h1, 0, l0);
      repeat (5) @(posedge clk);
      #1;
      do_reset();
      checks++;
      if (gpio_out !== 0 || sdata_out !== 0) begin
         errors++;
         $display("FAIL midjob-reset outputs: got %h %h want 0 0", gpio_out, sdata_out);
      end
      status_check("midjob_reset", 32'h2);
   endtask

   initial begin
      test_reset();
      test_unmapped();
      test_gpio();
      test_euclid();
      test_stein();
      test_zero();
      test_fifo_full();
      test_flush();
      test_abort();
      test_reset_midjob();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
